// File: rtl/bcd_seg_scan_if.sv
// Display bus between the BCD counters and the scan driver.
// The master drives the counter value; the slave drives the display pins.
interface bcd_seg_scan_if;
   logic [15:0] bcd_in;
   logic        load;
   logic [3:0]  dp_mask;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        err;

   modport master (output bcd_in, load, dp_mask, input an, seg, err);
   modport slave  (input bcd_in, load, dp_mask, output an, seg, err);
endinterface

// File: rtl/bcd_seg_scan.sv
// Snapshots a 4-digit packed-BCD word and multiplexes it onto a common-anode
// seven-segment display with leading-zero blanking, decimal points and an error flag.
module bcd_seg_scan #(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input logic           i_clk,
   input logic           i_reset,
   bcd_seg_scan_if.slave bus
);
   localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [DW-1:0] r_div;
   logic [1:0]    r_idx;
   logic [15:0]   r_shadow;
   logic          r_err;
   logic [3:0]    r_an;
   logic [7:0]    r_seg;

   logic [3:0]    w_nib;
   logic          w_blank;
   logic [6:0]    w_glyph;
   logic          w_bad_in;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h3F;
      endcase
   endfunction

   always_comb begin
      w_bad_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (bus.bcd_in[k*4 +: 4] > 4'd9) w_bad_in = 1'b1;
      end
   end

   assign w_nib = r_shadow[{r_idx, 2'b00} +: 4];

   // A digit is a leading zero only if it and every digit above it are zero;
   // an invalid nibble is non-zero, so it stops the blanking.
   always_comb begin
      w_blank = 1'b0;
      case (r_idx)
         2'd3:    w_blank = (r_shadow[15:12] == 4'h0);
         2'd2:    w_blank = (r_shadow[15:8]  == 8'h00);
         2'd1:    w_blank = (r_shadow[15:4]  == 12'h000);
         default: w_blank = 1'b0;
      endcase
      if (!BLANK_LZ) w_blank = 1'b0;
   end

   assign w_glyph = w_blank ? 7'h7F : seg7(w_nib);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_div    <= '0;
         r_idx    <= 2'd0;
         r_shadow <= 16'h0000;
         r_err    <= 1'b0;
         r_an     <= 4'b1111;
         r_seg    <= 8'hFF;
      end else begin
         if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_div <= r_div + DW'(1);
         end
         if (bus.load) begin
            r_shadow <= bus.bcd_in;
            r_err    <= w_bad_in;
         end
         r_an  <= ~(4'b0001 << r_idx);
         r_seg <= {~bus.dp_mask[r_idx], w_glyph};
      end
   end

   assign bus.an  = r_an;
   assign bus.seg = r_seg;
   assign bus.err = r_err;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: a value-level display model checked every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_bcd_seg_scan;
   localparam int SD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bcd_seg_scan_if bif ();

   bcd_seg_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bif)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [15:0] cl_val [5] = '{16'h0000, 16'h00F0, 16'h1234, 16'h9999, 16'hA000};
   logic        cl_err [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   // Model state: counter value and how many edges have elapsed since reset.
   logic [15:0] m_sh;
   logic        m_err;
   logic [3:0]  m_an;
   logic [7:0]  m_seg;
   int          m_cnt;

   function automatic logic [7:0] exp_seg(input logic [15:0] v, input int d, input logic [3:0] dp);
      logic [15:0] above;
      int nib;
      logic [6:0] g;
      above = v >> (4 * d);
      nib   = int'(above & 16'h000F);
      if (d > 0 && above == 16'h0) g = 7'h7F;
      else if (nib > 9)            g = 7'h3F;
      else                         g = glyph[nib];
      return {~dp[d], g};
   endfunction

   function automatic logic any_bad(input logic [15:0] v);
      for (int k = 0; k < 4; k++) begin
         if (((v >> (4 * k)) & 16'h000F) > 16'd9) return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_sh = 16'h0; m_err = 1'b0; m_an = 4'hF; m_seg = 8'hFF; m_cnt = 0;
      end else begin : run
         int d;
         d     = (m_cnt / SD) % 4;
         m_an  = ~(4'b0001 << d);
         m_seg = exp_seg(m_sh, d, bif.dp_mask);
         m_cnt = m_cnt + 1;
         if (bif.load) begin
            m_sh  = bif.bcd_in;
            m_err = any_bad(bif.bcd_in);
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model.an",  {12'h0, bif.an},  {12'h0, m_an});
         chk("model.seg", {8'h0, bif.seg},  {8'h0, m_seg});
         chk("model.err", {15'h0, bif.err}, {15'h0, m_err});
      end
   end

   task automatic wait_an(input logic [3:0] a, output int c);
      c = 0;
      while (bif.an !== a && c < 40) begin
         @(negedge clk);
         c++;
      end
      if (bif.an !== a) begin
         tests++; fails++;
         $display("FAIL wait_an: got %h expected %h (timeout)", bif.an, a);
      end
   endtask

   task automatic wait_digit(input int k, input logic [7:0] s, input string nm);
      int c;
      wait_an(~(4'b0001 << k), c);
      chk(nm, {8'h0, bif.seg}, {8'h0, s});
   endtask

   task automatic do_load(input logic [15:0] v);
      bif.bcd_in = v;
      bif.load   = 1'b1;
      @(negedge clk);
      bif.load   = 1'b0;
   endtask

   task automatic wait_phase(input int ph);
      int c;
      c = 0;
      while ((m_cnt % 16) != ph && c < 40) begin
         @(negedge clk);
         c++;
      end
      if ((m_cnt % 16) != ph) begin
         tests++; fails++;
         $display("FAIL wait_phase: got %0d expected %0d (timeout)", m_cnt % 16, ph);
      end
   endtask

   initial begin
      int c0, c1, c2;
      bif.bcd_in = 16'h0; bif.load = 1'b0; bif.dp_mask = 4'h0; rst_n = 1'b0;

      // 1: reset then zero display scan
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst.an",  {12'h0, bif.an}, 16'h000F);
      chk("rst.seg", {8'h0, bif.seg}, 16'h00FF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1.n1.an",  {12'h0, bif.an}, 16'h000E);
      chk("t1.n1.seg", {8'h0, bif.seg}, 16'h00C0);
      repeat (3) @(negedge clk);
      chk("t1.n4.an",  {12'h0, bif.an}, 16'h000E);
      @(negedge clk);
      chk("t1.n5.an",  {12'h0, bif.an}, 16'h000D);
      chk("t1.n5.seg", {8'h0, bif.seg}, 16'h00FF);
      repeat (4) @(negedge clk);
      chk("t1.n9.an",  {12'h0, bif.an}, 16'h000B);
      repeat (4) @(negedge clk);
      chk("t1.n13.an", {12'h0, bif.an}, 16'h0007);
      repeat (4) @(negedge clk);
      chk("t1.n17.an",  {12'h0, bif.an}, 16'h000E);
      chk("t1.n17.seg", {8'h0, bif.seg}, 16'h00C0);

      // 2: millisecond value and scan period
      do_load(16'h0999);
      chk("t2.err", {15'h0, bif.err}, 16'h0000);
      @(negedge clk);
      wait_digit(0, 8'h90, "t2.d0");
      wait_digit(1, 8'h90, "t2.d1");
      wait_digit(2, 8'h90, "t2.d2");
      wait_digit(3, 8'hFF, "t2.d3");
      wait_an(4'hE, c0);
      wait_an(4'h7, c1);
      wait_an(4'hE, c2);
      chk("t2.period", 16'(c1 + c2), 16'd16);

      // 3: invalid nibble
      do_load(16'h1A05);
      chk("t3.err1", {15'h0, bif.err}, 16'h0001);
      @(negedge clk);
      wait_digit(0, 8'h92, "t3.d0");
      wait_digit(1, 8'hC0, "t3.d1");
      wait_digit(2, 8'hBF, "t3.d2");
      wait_digit(3, 8'hF9, "t3.d3");
      do_load(16'h0001);
      chk("t3.err0", {15'h0, bif.err}, 16'h0000);

      // 4: decimal point on a blanked digit
      bif.dp_mask = 4'b0100;
      do_load(16'h0012);
      @(negedge clk);
      wait_digit(2, 8'h7F, "t4.d2");
      wait_digit(3, 8'hFF, "t4.d3");
      wait_digit(1, 8'hF9, "t4.d1");
      wait_digit(0, 8'hA4, "t4.d0");
      bif.dp_mask = 4'b0000;

      // 5: load while idx=1, div=2
      wait_phase(6);
      do_load(16'h0005);
      chk("t5.an.a", {12'h0, bif.an}, 16'h000D);
      repeat (2) @(negedge clk);
      chk("t5.an.b", {12'h0, bif.an}, 16'h000B);
      wait_digit(0, 8'h92, "t5.d0");

      // continuous load tracks bcd_in every cycle
      bif.load = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bif.bcd_in = cl_val[i];
         @(negedge clk);
         chk("cl.err", {15'h0, bif.err}, {15'h0, cl_err[i]});
      end
      bif.load = 1'b0;

      // 6: reset mid-operation with err set
      do_load(16'h1A05);
      wait_phase(9);
      chk("t6.pre.err", {15'h0, bif.err}, 16'h0001);
      chk("t6.pre.an",  {12'h0, bif.an}, 16'h000B);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6.rst.an",  {12'h0, bif.an}, 16'h000F);
      chk("t6.rst.seg", {8'h0, bif.seg}, 16'h00FF);
      chk("t6.rst.err", {15'h0, bif.err}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6.rel.an",  {12'h0, bif.an}, 16'h000E);
      chk("t6.rel.seg", {8'h0, bif.seg}, 16'h00C0);
      repeat (3) @(negedge clk);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
